exhaustive_pattern_sequencer: RTL and testbench

EXHAUSTIVE_PATTERN_SEQUENCER -- requirements
Module: exhaustive_pattern_sequencer

---
 rtl/exhaustive_pattern_sequencer_if.sv | 29 ++
 rtl/exhaustive_pattern_sequencer.sv | 128 ++++++++++++
 tb/tb_exhaustive_pattern_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exhaustive_pattern_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : exhaustive_pattern_sequencer_if
// Brief    : Pattern drive / response capture bundle between the sequencer
//            (master) and the device under test plus capture consumer (slave).
// Revision : 1.0
// ============================================================================
interface exhaustive_pattern_sequencer_if #(
    parameter int N_WIDTH   = 3,
    parameter int OUT_WIDTH = 1
);
    logic [N_WIDTH-1:0]   N;
    logic [OUT_WIDTH-1:0] dut_out;
    logic                 cap_valid;
    logic                 cap_ready;
    logic [N_WIDTH-1:0]   cap_pattern;
    logic [OUT_WIDTH-1:0] cap_response;

    modport master (
        output N, cap_valid, cap_pattern, cap_response,
        input  dut_out, cap_ready
    );

    modport slave (
        input  N, cap_valid, cap_pattern, cap_response,
        output dut_out, cap_ready
    );
endinterface
`default_nettype wire

// File: rtl/exhaustive_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exhaustive_pattern_sequencer
// Brief    : Walks every input pattern (binary or Gray order), captures each
//            settled response through a valid/ready pair and compacts a MISR.
// Revision : 1.0
// ============================================================================
module exhaustive_pattern_sequencer #(
    parameter int N_WIDTH       = 3,
    parameter int OUT_WIDTH     = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int GRAY_MODE     = 0
) (
    input  logic                           CK,
    input  logic                           reset,
    input  logic                           start,
    exhaustive_pattern_sequencer_if.master bus,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    signature
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Index carries one spare bit so the terminal compare can never wrap.
    localparam logic [N_WIDTH:0] c_last_index = {1'b0, {N_WIDTH{1'b1}}};
    localparam logic [7:0]       c_settle     = 8'(SETTLE_CYCLES);

    state_t               r_state;
    logic [N_WIDTH:0]     r_index;
    logic [7:0]           r_cnt;
    logic [N_WIDTH-1:0]   r_n;
    logic                 r_cap_valid;
    logic [N_WIDTH-1:0]   r_cap_pattern;
    logic [OUT_WIDTH-1:0] r_cap_response;
    logic                 r_busy;
    logic                 r_done;
    logic [15:0]          r_sig;

    logic [N_WIDTH:0]     w_idx_next;
    logic [7:0]           w_cnt_next;
    logic                 w_handshake;
    logic [15:0]          w_sig_next;

    function automatic logic [N_WIDTH-1:0] f_map(input logic [N_WIDTH-1:0] idx);
        if (GRAY_MODE != 0) begin
            return idx ^ (idx >> 1);
        end
        return idx;
    endfunction

    assign w_idx_next  = r_index + 1'b1;
    assign w_cnt_next  = r_cnt + 8'd1;
    assign w_handshake = r_cap_valid && bus.cap_ready;
    assign w_sig_next  = {r_sig[14:0], r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10]}
                         ^ 16'(r_cap_response);

    always_ff @(posedge CK) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_index        <= '0;
            r_cnt          <= '0;
            r_n            <= '0;
            r_cap_valid    <= 1'b0;
            r_cap_pattern  <= '0;
            r_cap_response <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sig          <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SETTLE;
                        r_index <= '0;
                        r_n     <= f_map({N_WIDTH{1'b0}});
                        r_cnt   <= '0;
                        r_sig   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= w_cnt_next;
                    // dut_out is only looked at on this single edge.
                    if (w_cnt_next == c_settle) begin
                        r_cap_response <= bus.dut_out;
                        r_cap_pattern  <= r_n;
                        r_cap_valid    <= 1'b1;
                        r_state        <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_handshake) begin
                        r_sig       <= w_sig_next;
                        r_cap_valid <= 1'b0;
                        if (r_index == c_last_index) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= w_idx_next;
                            r_n     <= f_map(w_idx_next[N_WIDTH-1:0]);
                            r_cnt   <= '0;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.N            = r_n;
    assign bus.cap_valid    = r_cap_valid;
    assign bus.cap_pattern  = r_cap_pattern;
    assign bus.cap_response = r_cap_response;
    assign busy             = r_busy;
    assign done             = r_done;
    assign signature        = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exhaustive_pattern_sequencer
// Brief    : Three sequencer configurations driven side by side against an
//            event-level reference model, plus table and directed sequences.
// Revision : 1.0
// ============================================================================
module tb_exhaustive_pattern_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic rdy0, rdy1, rdy2;
    logic busy0, busy1, busy2, done0, done1, done2;
    logic [15:0] sig0, sig1, sig2;

    // id0: binary, settle 1, table-driven response; id1: Gray, settle 4,
    // response is a registered copy of N; id2: single-input, response tied.
    exhaustive_pattern_sequencer_if #(.N_WIDTH(3), .OUT_WIDTH(4)) if0 ();
    exhaustive_pattern_sequencer_if #(.N_WIDTH(3), .OUT_WIDTH(3)) if1 ();
    exhaustive_pattern_sequencer_if #(.N_WIDTH(1), .OUT_WIDTH(1)) if2 ();

    exhaustive_pattern_sequencer #(.N_WIDTH(3), .OUT_WIDTH(4), .SETTLE_CYCLES(1), .GRAY_MODE(0)) u_dut0 (
        .CK(clk), .reset(rst), .start(start), .bus(if0.master),
        .busy(busy0), .done(done0), .signature(sig0));
    exhaustive_pattern_sequencer #(.N_WIDTH(3), .OUT_WIDTH(3), .SETTLE_CYCLES(4), .GRAY_MODE(1)) u_dut1 (
        .CK(clk), .reset(rst), .start(start), .bus(if1.master),
        .busy(busy1), .done(done1), .signature(sig1));
    exhaustive_pattern_sequencer #(.N_WIDTH(1), .OUT_WIDTH(1), .SETTLE_CYCLES(1), .GRAY_MODE(0)) u_dut2 (
        .CK(clk), .reset(rst), .start(start), .bus(if2.master),
        .busy(busy2), .done(done2), .signature(sig2));

    logic       tie_en0;
    logic [3:0] tie0;
    logic [3:0] lut0 [8];
    logic       glitch1;
    logic [2:0] noise1, ncopy1;
    logic       tie2;

    always @(posedge clk) ncopy1 <= if1.N;

    assign if0.dut_out   = tie_en0 ? tie0 : lut0[if0.N];
    assign if1.dut_out   = glitch1 ? noise1 : ncopy1;
    assign if2.dut_out   = tie2;
    assign if0.cap_ready = rdy0;
    assign if1.cap_ready = rdy1;
    assign if2.cap_ready = rdy2;

    int checks = 0;
    int errors = 0;
    int rmode;

    int nw [3] = '{3, 3, 1};
    int sc [3] = '{1, 4, 1};
    int gm [3] = '{0, 1, 0};
    bit act [3];
    bit dn [3];
    int k [3];
    int since [3];
    int dcyc [3];
    logic [15:0] msig [3];
    logic [15:0] gq [$];

    typedef struct {
        logic [3:0]  tie0;
        logic        tie2;
        logic [15:0] sig0;
        logic [15:0] sig2;
    } vec_t;
    vec_t vt [3];
    logic [15:0] gray_tab [8];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic obs(input int id, output logic [15:0] n, output logic [15:0] p,
                       output logic [15:0] r, output logic [15:0] s,
                       output logic v, output logic b, output logic d, output logic rd);
        case (id)
            0: begin n = 16'(if0.N); p = 16'(if0.cap_pattern); r = 16'(if0.cap_response);
                     s = sig0; v = if0.cap_valid; b = busy0; d = done0; rd = rdy0; end
            1: begin n = 16'(if1.N); p = 16'(if1.cap_pattern); r = 16'(if1.cap_response);
                     s = sig1; v = if1.cap_valid; b = busy1; d = done1; rd = rdy1; end
            default: begin n = 16'(if2.N); p = 16'(if2.cap_pattern); r = 16'(if2.cap_response);
                     s = sig2; v = if2.cap_valid; b = busy2; d = done2; rd = rdy2; end
        endcase
    endtask

    function automatic logic [15:0] pmap(input int id, input int idx);
        logic [15:0] x;
        x = 16'(idx);
        if (gm[id] != 0) x = x ^ (x >> 1);
        return x & 16'((1 << nw[id]) - 1);
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] r);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ r;
    endfunction

    function automatic logic [15:0] eresp(input int id, input logic [15:0] pat);
        case (id)
            0:       return tie_en0 ? 16'(tie0) : 16'(lut0[pat[2:0]]);
            1:       return pat;
            default: return 16'(tie2);
        endcase
    endfunction

    // One clock: drive inputs, let the edge happen, then advance the model.
    task automatic cycle(input logic st, input logic rs);
        logic [15:0] n, p, r, s;
        logic v, b, d, rd;
        logic vb [3];
        logic rb [3];
        logic [15:0] pb [3];
        for (int id = 0; id < 3; id++) begin
            obs(id, n, p, r, s, v, b, d, rd);
            vb[id] = v; pb[id] = p;
        end
        if (rmode == 0) begin
            rdy0 = 1'($urandom); rdy1 = 1'($urandom); rdy2 = 1'($urandom);
        end else if (rmode == 1) begin
            rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        end
        rb[0] = rdy0; rb[1] = rdy1; rb[2] = rdy2;
        glitch1 = act[1] && !(!vb[1] && (since[1] + 1 == sc[1]));
        noise1  = 3'($urandom);
        start = st;
        rst   = rs;
        @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            obs(id, n, p, r, s, v, b, d, rd);
            if (rs) begin
                act[id] = 0; dn[id] = 0; k[id] = 0; msig[id] = '0;
                chk($sformatf("id%0d rst_N", id), n, 16'h0);
                chk($sformatf("id%0d rst_pat", id), p, 16'h0);
                chk($sformatf("id%0d rst_resp", id), r, 16'h0);
                chk($sformatf("id%0d rst_flags", id), {13'h0, v, b, d}, 16'h0);
                chk($sformatf("id%0d rst_sig", id), s, 16'h0);
            end else if (!act[id]) begin
                if (st) begin
                    act[id] = 1; dn[id] = 0; k[id] = 0; since[id] = 0; msig[id] = '0;
                    chk($sformatf("id%0d start_N", id), n, pmap(id, 0));
                end
                chk($sformatf("id%0d flags", id), {13'h0, v, b, d}, {13'h0, 1'b0, act[id], dn[id]});
                chk($sformatf("id%0d sig", id), s, msig[id]);
            end else begin
                if (vb[id] && rb[id]) begin
                    if (id == 1) gq.push_back(pb[1]);
                    msig[id] = misr(msig[id], eresp(id, pmap(id, k[id])));
                    k[id]++;
                    if (k[id] == (1 << nw[id])) begin
                        act[id] = 0; dn[id] = 1;
                    end else begin
                        since[id] = 0;
                        chk($sformatf("id%0d next_N", id), n, pmap(id, k[id]));
                    end
                    chk($sformatf("id%0d hs_flags", id), {13'h0, v, b, d}, {13'h0, 1'b0, act[id], dn[id]});
                end else begin
                    since[id]++;
                    chk($sformatf("id%0d hold_N", id), n, pmap(id, k[id]));
                    chk($sformatf("id%0d flags", id), {13'h0, v, b, d},
                        {13'h0, (since[id] >= sc[id]), 1'b1, 1'b0});
                    if (since[id] >= sc[id]) begin
                        chk($sformatf("id%0d cap_pattern", id), p, pmap(id, k[id]));
                        chk($sformatf("id%0d cap_response", id), r, eresp(id, pmap(id, k[id])));
                    end
                end
                chk($sformatf("id%0d sig", id), s, msig[id]);
            end
        end
    endtask

    task automatic finish_sweep(input bit rnd_start);
        logic [15:0] n, p, r, s;
        logic v, b, d, rd;
        int cnt;
        cnt = 0;
        while ((act[0] || act[1] || act[2]) && cnt < 400) begin
            cycle(rnd_start && act[0] && ($urandom_range(0, 5) == 0), 1'b0);
            cnt++;
            for (int id = 0; id < 3; id++) begin
                obs(id, n, p, r, s, v, b, d, rd);
                if (dcyc[id] < 0 && d) dcyc[id] = cnt;
            end
        end
        if (cnt >= 400) chk("sweep_timeout", 16'(cnt), 16'(0));
    endtask

    task automatic run_sweep(input bit rnd_start);
        for (int id = 0; id < 3; id++) dcyc[id] = -1;
        cycle(1'b1, 1'b0);
        finish_sweep(rnd_start);
    endtask

    initial begin
        logic [15:0] n, p, r, s;
        logic v, b, d, rd;

        vt[0] = '{4'h0, 1'b0, 16'h0000, 16'h0000};
        vt[1] = '{4'h1, 1'b1, 16'h00FF, 16'h0003};
        vt[2] = '{4'hF, 1'b0, 16'h0505, 16'h0000};
        gray_tab = '{16'd0, 16'd1, 16'd3, 16'd2, 16'd6, 16'd7, 16'd5, 16'd4};

        rst = 1'b1; start = 1'b0; rdy0 = 0; rdy1 = 0; rdy2 = 0;
        tie_en0 = 1'b0; tie0 = '0; tie2 = 1'b0; glitch1 = 1'b0; noise1 = '0;
        for (int i = 0; i < 8; i++) lut0[i] = 4'($urandom);
        for (int id = 0; id < 3; id++) begin
            act[id] = 0; dn[id] = 0; k[id] = 0; since[id] = 0; msig[id] = '0; dcyc[id] = -1;
        end
        rmode = 2;

        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Constant responses with ready held high: final signature and sweep length.
        tie_en0 = 1'b1;
        rmode   = 1;
        for (int i = 0; i < 3; i++) begin
            tie0 = vt[i].tie0;
            tie2 = vt[i].tie2;
            cycle(1'b0, 1'b1);
            gq.delete();
            run_sweep(1'b0);
            chk($sformatf("tab%0d sig0", i), sig0, vt[i].sig0);
            chk($sformatf("tab%0d sig2", i), sig2, vt[i].sig2);
            chk($sformatf("tab%0d done_cyc0", i), 16'(dcyc[0]), 16'd16);
            chk($sformatf("tab%0d done_cyc1", i), 16'(dcyc[1]), 16'd40);
            chk($sformatf("tab%0d done_cyc2", i), 16'(dcyc[2]), 16'd4);
            if (i == 0) begin
                chk("gray_count", 16'(gq.size()), 16'd8);
                for (int j = 0; j < 8 && j < gq.size(); j++)
                    chk($sformatf("gray_order%0d", j), gq[j], gray_tab[j]);
            end
        end

        // Consumer stalls for several cycles mid-capture, then releases.
        tie_en0 = 1'b0;
        rmode = 2; rdy0 = 0; rdy1 = 0; rdy2 = 0;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
        obs(0, n, p, r, s, v, b, d, rd);
        chk("stall_valid", 16'(v), 16'd1);
        rmode = 1;
        finish_sweep(1'b0);

        // Reset lands on the edge of the fourth handshake, then a clean sweep.
        rmode = 1;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 20 && !(k[0] == 3 && if0.cap_valid); i++) cycle(1'b0, 1'b0);
        chk("pre_reset_valid", 16'(if0.cap_valid), 16'd1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        run_sweep(1'b0);

        // Random responses, random ready, stray start pulses mid-sweep.
        rmode = 0;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) lut0[i] = 4'($urandom);
            run_sweep(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
